mix_scheduler: RTL and testbench

MIX_SCHEDULER -- requirements
Module: mix_scheduler

---
 rtl/mix_pkg.sv | 19 +
 rtl/mix_acc.sv | 50 +++++
 rtl/mix_scheduler.sv | 141 ++++++++++++++
 tb/tb_mix_scheduler.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mix_pkg.sv
// Shared definitions for the audio mix scheduler: FSM states, default
// geometry and the accumulator width rule.
package mix_pkg;

  localparam int DEF_L = 24;
  localparam int DEF_N = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    SAT  = 2'd2
  } state_t;

  // Width that holds the sum of n signed l-bit samples without overflow.
  function automatic int acc_width(input int l, input int n);
    return l + $clog2(n);
  endfunction

endpackage

// File: rtl/mix_acc.sv
// Mix accumulator: clears at frame start, adds sign-extended samples and
// presents the clamped L-bit result together with a clip indication.
module mix_acc
  import mix_pkg::*;
#(
  parameter int L     = DEF_L,
  parameter int ACC_W = acc_width(DEF_L, DEF_N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_add,
  input  logic [L-1:0] i_sample,
  output logic [L-1:0] o_sat,
  output logic         o_clip
);

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-L+1){1'b0}}, {(L-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-L+1){1'b1}}, {(L-1){1'b0}}};

  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_ext;

  assign w_ext = {{(ACC_W-L){i_sample[L-1]}}, i_sample};

  // Running sum for the current frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_add) begin
      r_acc <= r_acc + w_ext;
    end
  end

  // Clamp the sum into the L-bit signed range and flag when clamping applies.
  always_comb begin
    o_sat  = r_acc[L-1:0];
    o_clip = 1'b0;
    if (r_acc > SAT_MAX) begin
      o_sat  = {1'b0, {(L-1){1'b1}}};
      o_clip = 1'b1;
    end else if (r_acc < SAT_MIN) begin
      o_sat  = {1'b1, {(L-1){1'b0}}};
      o_clip = 1'b1;
    end
  end

endmodule

// File: rtl/mix_scheduler.sv
// Audio mix scheduler: on each LRCLK falling-edge strobe, polls enabled
// channels one per cycle, sums their samples, saturates and publishes the
// mix with a one-cycle valid pulse. Tracks overrun/underrun/clip status.
module mix_scheduler
  import mix_pkg::*;
#(
  parameter int L = DEF_L,
  parameter int N = DEF_N
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           next_lrclk_fall,
  input  logic [N*L-1:0] ch_data,
  input  logic [N-1:0]   ch_valid,
  input  logic [N-1:0]   ch_mask,
  input  logic           clear_flags,
  output logic [N-1:0]   ch_ready,
  output logic [L-1:0]   mix_out,
  output logic           mix_valid,
  output logic           busy,
  output logic           overrun,
  output logic           underrun,
  output logic           clipped
);

  localparam int ACC_W = acc_width(L, N);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t         r_state;
  state_t         w_next;
  logic [IDX_W-1:0] r_idx;
  logic [N-1:0]   r_mask;
  logic           w_start;
  logic           w_scan;
  logic           w_sat;
  logic           w_add;
  logic           w_under;
  logic           w_over;
  logic           w_clip;
  logic [L-1:0]   w_sample;
  logic [L-1:0]   w_sat_val;

  assign w_sample = ch_data[r_idx*L +: L];
  assign w_add    = w_scan & r_mask[r_idx] & ch_valid[r_idx];
  assign w_under  = w_scan & r_mask[r_idx] & ~ch_valid[r_idx];
  assign w_over   = busy & next_lrclk_fall;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: one frame is IDLE -> SCAN (N cycles) -> SAT -> IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (next_lrclk_fall) w_next = SCAN;
      SCAN:    if (r_idx == LAST_IDX) w_next = SAT;
      SAT:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State-decoded controls: grant only the polled, enabled channel.
  always_comb begin
    ch_ready = '0;
    busy     = 1'b0;
    w_start  = 1'b0;
    w_scan   = 1'b0;
    w_sat    = 1'b0;
    case (r_state)
      IDLE: w_start = next_lrclk_fall;
      SCAN: begin
        busy            = 1'b1;
        w_scan          = 1'b1;
        ch_ready[r_idx] = r_mask[r_idx];
      end
      SAT: begin
        busy  = 1'b1;
        w_sat = 1'b1;
      end
      default: ;
    endcase
  end

  // Channel index and per-frame enable snapshot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx  <= '0;
      r_mask <= '0;
    end else if (w_start) begin
      r_idx  <= '0;
      r_mask <= ch_mask;
    end else if (w_scan) begin
      r_idx  <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
    end
  end

  // Publish the saturated mix once per frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mix_out   <= '0;
      mix_valid <= 1'b0;
    end else begin
      mix_valid <= w_sat;
      if (w_sat) mix_out <= w_sat_val;
    end
  end

  // Sticky status; a set event beats a simultaneous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun  <= 1'b0;
      underrun <= 1'b0;
      clipped  <= 1'b0;
    end else begin
      overrun  <= w_over | (overrun & ~clear_flags);
      underrun <= w_under | (underrun & ~clear_flags);
      clipped  <= (w_sat & w_clip) | (clipped & ~clear_flags);
    end
  end

  mix_acc #(
    .L     (L),
    .ACC_W (ACC_W)
  ) u_acc (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (w_start),
    .i_add    (w_add),
    .i_sample (w_sample),
    .o_sat    (w_sat_val),
    .o_clip   (w_clip)
  );

endmodule

// File: tb/tb_mix_scheduler.sv
// Bench for mix_scheduler: a frame-level reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_mix_scheduler;

  localparam int L = 24;
  localparam int N = 4;

  logic           clk;
  logic           reset;
  logic           next_lrclk_fall;
  logic [N*L-1:0] ch_data;
  logic [N-1:0]   ch_valid;
  logic [N-1:0]   ch_mask;
  logic           clear_flags;
  logic [N-1:0]   ch_ready;
  logic [L-1:0]   mix_out;
  logic           mix_valid;
  logic           busy;
  logic           overrun;
  logic           underrun;
  logic           clipped;

  int n_vec = 0;
  int n_err = 0;
  int n_mv  = 0;

  mix_scheduler #(
    .L (L),
    .N (N)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .next_lrclk_fall (next_lrclk_fall),
    .ch_data         (ch_data),
    .ch_valid        (ch_valid),
    .ch_mask         (ch_mask),
    .clear_flags     (clear_flags),
    .ch_ready        (ch_ready),
    .mix_out         (mix_out),
    .mix_valid       (mix_valid),
    .busy            (busy),
    .overrun         (overrun),
    .underrun        (underrun),
    .clipped         (clipped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_phase: 0 idle, k=1..N polling channel k-1, N+1 publishing.
  int          m_phase = 0;
  logic [N-1:0] m_mask = '0;
  longint      m_acc = 0;
  logic [L-1:0] m_mix = '0;
  logic        m_mv = 1'b0, m_ovr = 1'b0, m_und = 1'b0, m_clip = 1'b0;
  logic        s_ovr, s_und, s_clip;
  int          m_ch;
  longint      m_hi, m_lo;

  function automatic longint sext(input logic [L-1:0] v);
    logic signed [L-1:0] s;
    s = v;
    return longint'(s);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase = 0; m_mask = '0; m_acc = 0; m_mix = '0;
      m_mv = 1'b0; m_ovr = 1'b0; m_und = 1'b0; m_clip = 1'b0;
    end else begin
      s_ovr = 1'b0; s_und = 1'b0; s_clip = 1'b0;
      m_mv  = 1'b0;
      if (m_phase == 0) begin
        if (next_lrclk_fall) begin
          m_mask  = ch_mask;
          m_acc   = 0;
          m_phase = 1;
        end
      end else if (m_phase <= N) begin
        m_ch = m_phase - 1;
        if (next_lrclk_fall) s_ovr = 1'b1;
        if (m_mask[m_ch]) begin
          if (ch_valid[m_ch]) m_acc += sext(ch_data[m_ch*L +: L]);
          else s_und = 1'b1;
        end
        m_phase++;
      end else begin
        if (next_lrclk_fall) s_ovr = 1'b1;
        m_hi = (longint'(1) <<< (L - 1)) - 1;
        m_lo = -(longint'(1) <<< (L - 1));
        if (m_acc > m_hi) begin
          m_mix = L'(m_hi); s_clip = 1'b1;
        end else if (m_acc < m_lo) begin
          m_mix = L'(m_lo); s_clip = 1'b1;
        end else begin
          m_mix = L'(m_acc);
        end
        m_mv    = 1'b1;
        m_phase = 0;
      end
      m_ovr  = s_ovr  | (m_ovr  & ~clear_flags);
      m_und  = s_und  | (m_und  & ~clear_flags);
      m_clip = s_clip | (m_clip & ~clear_flags);
    end
  end

  function automatic logic [N-1:0] m_ready();
    logic [N-1:0] r;
    r = '0;
    if (m_phase >= 1 && m_phase <= N && m_mask[m_phase-1]) r[m_phase-1] = 1'b1;
    return r;
  endfunction

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("ch_ready",  ch_ready,  m_ready());
    chk("busy",      busy,      m_phase != 0);
    chk("mix_valid", mix_valid, m_mv);
    chk("mix_out",   mix_out,   m_mix);
    chk("overrun",   overrun,   m_ovr);
    chk("underrun",  underrun,  m_und);
    chk("clipped",   clipped,   m_clip);
    if (mix_valid) n_mv++;
  end

  // ---------------- directed stimulus ----------------
  logic [N-1:0] rtrace [0:20];
  int           lat;
  int           mv0;

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_all(input logic [L-1:0] v);
    for (int i = 0; i < N; i++) ch_data[i*L +: L] = v;
  endtask

  // Strobe one frame and wait (bounded) for its mix_valid.
  task automatic run_frame();
    for (int k = 0; k <= 20; k++) rtrace[k] = '0;
    next_lrclk_fall = 1'b1;
    cyc();
    next_lrclk_fall = 1'b0;
    rtrace[0] = ch_ready;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      rtrace[k] = ch_ready;
      if (mix_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1;
    cyc();
    clear_flags = 1'b0;
  endtask

  initial begin
    next_lrclk_fall = 1'b0;
    clear_flags     = 1'b0;
    ch_data         = '0;
    ch_valid        = '0;
    ch_mask         = '0;
    reset           = 1'b1;
    #1 reset = 1'b0;
    repeat (2) cyc();
    chk("rst_mix_out", mix_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", ch_ready, 0);
    chk("rst_flags", {overrun, underrun, clipped}, 0);
    reset = 1'b1;
    repeat (2) cyc();

    // Basic mix on ch0+ch1; masked-off channels hold junk that must not count.
    ch_data[0*L +: L] = 24'h100000;
    ch_data[1*L +: L] = 24'h200000;
    ch_data[2*L +: L] = 24'h555555;
    ch_data[3*L +: L] = 24'h123456;
    ch_valid = 4'b1111;
    ch_mask  = 4'b0011;
    run_frame();
    chk("basic_lat", lat, 5);
    chk("basic_mix", mix_out, 24'h300000);
    chk("basic_rdy0", rtrace[0], 4'b0001);
    chk("basic_rdy1", rtrace[1], 4'b0010);
    chk("basic_rdy2", rtrace[2], 4'b0000);
    chk("basic_flags", {overrun, underrun, clipped}, 0);

    // Strobe on the mix_valid cycle starts a fresh frame.
    ch_mask = 4'b0001;
    run_frame();
    chk("b2b_lat", lat, 5);
    chk("b2b_mix", mix_out, 24'h100000);
    chk("b2b_ovr", overrun, 0);

    // Positive saturation.
    set_all(24'h7FFFFF);
    ch_mask = 4'b1111;
    run_frame();
    chk("pos_mix", mix_out, 24'h7FFFFF);
    chk("pos_clip", clipped, 1);
    pulse_clear();
    chk("pos_clr", clipped, 0);

    // Negative saturation.
    set_all(24'h800000);
    run_frame();
    chk("neg_mix", mix_out, 24'h800000);
    chk("neg_clip", clipped, 1);
    pulse_clear();

    // Underrun on ch2: grant still pulses, contributes zero.
    set_all(24'h000010);
    ch_valid = 4'b1011;
    run_frame();
    chk("und_mix", mix_out, 24'h000030);
    chk("und_flag", underrun, 1);
    chk("und_rdy2", rtrace[2], 4'b0100);
    chk("und_clip", clipped, 0);
    pulse_clear();
    chk("und_clr", underrun, 0);
    ch_valid = 4'b1111;

    // Overrun: second strobe two cycles in is ignored.
    mv0 = n_mv;
    next_lrclk_fall = 1'b1; cyc();
    next_lrclk_fall = 1'b0; cyc();
    next_lrclk_fall = 1'b1; cyc();
    next_lrclk_fall = 1'b0;
    repeat (12) cyc();
    chk("ovr_mv_count", n_mv - mv0, 1);
    chk("ovr_flag", overrun, 1);
    chk("ovr_mix", mix_out, 24'h000040);
    pulse_clear();
    chk("ovr_clr", overrun, 0);
    // New overrun coincides with clear: set wins.
    next_lrclk_fall = 1'b1; cyc();
    next_lrclk_fall = 1'b0; cyc();
    next_lrclk_fall = 1'b1; clear_flags = 1'b1; cyc();
    next_lrclk_fall = 1'b0; clear_flags = 1'b0;
    chk("ovr_set_wins", overrun, 1);
    repeat (8) cyc();
    pulse_clear();

    // Reset while polling channel 1.
    ch_mask = 4'b1111;
    next_lrclk_fall = 1'b1; cyc();
    next_lrclk_fall = 1'b0; cyc();
    chk("mid_rdy_before", ch_ready, 4'b0010);
    #1 reset = 1'b0;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_ready", ch_ready, 0);
    chk("mid_mix_out", mix_out, 0);
    chk("mid_mix_valid", mix_valid, 0);
    mv0 = n_mv;
    cyc();
    reset = 1'b1;
    repeat (10) cyc();
    chk("mid_no_mv", n_mv - mv0, 0);
    chk("mid_idle", busy, 0);
    ch_data[1*L +: L] = 24'h000123;
    ch_data[2*L +: L] = 24'hFFFFFF;
    ch_mask = 4'b0110;
    run_frame();
    chk("post_lat", lat, 5);
    chk("post_mix", mix_out, 24'h000122);
    chk("post_rdy1", rtrace[1], 4'b0010);
    chk("post_rdy2", rtrace[2], 4'b0100);

    repeat (3) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
